// File: rtl/md_hilo_sequencer_if.sv
// Handshake and HI/LO bus between the control unit and the mult/div sequencer.
interface md_hilo_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       fun_c;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, fun_c, a, b, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, fun_c, a, b, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/md_hilo_sequencer.sv
// Iterative shift-add multiply / restoring divide sequencer owning the HI/LO registers.
module md_hilo_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  md_hilo_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] p_hi_q, p_lo_q, opnd_q;
  logic             neg_q_q, neg_r_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_signed = op_q[0];
    is_div    = op_q[1];
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
    // and bit WIDTH of the difference is a clean borrow flag.
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q_q ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    quot_fix  = neg_q_q ? -p_lo_q : p_lo_q;
    rem_fix   = neg_r_q ? -p_hi_q : p_hi_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      opnd_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q  <= bus.a;
          b_q  <= bus.b;
          op_q <= bus.fun_c;
        end
        PREP: begin
          p_hi_q  <= '0;
          p_lo_q  <= a_mag;
          opnd_q  <= b_mag;
          neg_q_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r_q <= is_signed & a_q[WIDTH-1];
          div0_q  <= (b_q == '0);
          cnt_q   <= '0;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              p_hi_q <= div_diff[WIDTH-1:0];
              p_lo_q <= {p_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              p_hi_q <= div_shift[WIDTH-1:0];
              p_lo_q <= {p_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            p_hi_q <= mul_sum[WIDTH:1];
            p_lo_q <= {mul_sum[0], p_lo_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // The FIX write takes priority over a coincident mthi/mtlo.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      if (state_q == FIX) begin
        if (is_div) begin
          if (div0_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end else begin
        if (bus.wr_hi) hi_q <= bus.wdata;
        if (bus.wr_lo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_md_hilo_sequencer.sv
// Scoreboard bench for md_hilo_sequencer: expected {hi,lo} queued at start, checked on done.
module tb_md_hilo_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_hilo_sequencer_if #(.WIDTH(W)) bus ();

  md_hilo_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, no result was expected", bus.hi, bus.lo);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.hi, bus.lo} !== e) begin
          miscompares++;
          $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                   bus.hi, bus.lo, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input logic [2*W-1:0] e);
    bus.start = 1'b1;
    bus.fun_c = f;
    bus.a     = x;
    bus.b     = y;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
    bus.wr_hi = h;
    bus.wr_lo = l;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, expected all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
    issue(2'b01, 32'd5, 32'd6, 1'b0, '0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h, expected all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 64'h0}) begin
      miscompares++;
      $display("FAIL reset_no_write: got busy=%b hi=%h lo=%h, expected 0/0/0",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_mult;
    int c;
    logic [1:0] ops[2] = '{2'b00, 2'b01};
    logic [2*W-1:0] res[2] = '{64'h00000001_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'h2, 1'b1, res[i]);
      wait_idle(c);
      vectors++;
      if (c !== 34) begin
        miscompares++;
        $display("FAIL mult_busy_len op=%0d: got %0d cycles, expected 34", i, c);
      end
      vectors++;
      if (bus.done !== 1'b1) begin
        miscompares++;
        $display("FAIL mult_done op=%0d: got done=%b, expected 1", i, bus.done);
      end
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL mult_done_pulse op=%0d: got done=%b, expected 0", i, bus.done);
      end
    end
  endtask

  task automatic test_div;
    int c;
    logic [1:0]     ops[4] = '{2'b11, 2'b10, 2'b11, 2'b11};
    logic [W-1:0]   xa[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100};
    logic [W-1:0]   xb[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [2*W-1:0] res[4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003,
                               64'h00000000_80000000, 64'h00000002_FFFFFFF2};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xa[i], xb[i], 1'b1, res[i]);
      wait_idle(c);
      vectors++;
      if (c !== 34) begin
        miscompares++;
        $display("FAIL div_busy_len case=%0d: got %0d cycles, expected 34", i, c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int c;
    issue(2'b10, 32'h1234, 32'h0, 1'b1, 64'h00001234_FFFFFFFF);
    wait_idle(c);
    vectors++;
    if (c !== 34) begin
      miscompares++;
      $display("FAIL divu0_busy_len: got %0d cycles, expected 34", c);
    end
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FF00, 32'h0, 1'b1, 64'hFFFFFF00_FFFFFFFF);
    wait_idle(c);
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int c;
    issue(2'b10, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.fun_c = 2'b00;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(c);
    vectors++;
    if (c + 5 !== 34) begin
      miscompares++;
      $display("FAIL start_busy_len: got %0d cycles, expected 34", c + 5);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_busy_ignored: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_mt_collision;
    int c;
    mt_write(1'b0, 1'b1, 32'h1111_1111);
    mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
    vectors++;
    if ({bus.hi, bus.lo} !== 64'hA5A5A5A5_11111111) begin
      miscompares++;
      $display("FAIL mthi_idle: got hi=%h lo=%h, expected hi=a5a5a5a5 lo=11111111", bus.hi, bus.lo);
    end
    issue(2'b01, 32'd3, 32'd4, 1'b1, 64'h00000000_0000000C);
    repeat (5) @(negedge clk);
    mt_write(1'b0, 1'b1, 32'hDEAD_0000);
    vectors++;
    if ({bus.busy, bus.lo} !== {1'b1, 32'hDEAD_0000}) begin
      miscompares++;
      $display("FAIL mtlo_run: got busy=%b lo=%h, expected busy=1 lo=dead0000", bus.busy, bus.lo);
    end
    wait_idle(c);
    @(negedge clk);
    mt_write(1'b1, 1'b1, 32'hFFFF_0000);
    issue(2'b00, 32'd3, 32'd4, 1'b1, 64'h00000000_0000000C);
    repeat (33) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fix_edge_busy: got busy=%b, expected 1", bus.busy);
    end
    mt_write(1'b1, 1'b0, 32'h7777_7777);
    vectors++;
    if ({bus.busy, bus.done, bus.hi} !== {2'b01, 32'h0}) begin
      miscompares++;
      $display("FAIL fix_edge_mthi: got busy=%b done=%b hi=%h, expected 0/1/00000000",
               bus.busy, bus.done, bus.hi);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.fun_c = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_busy;
    test_mt_collision;
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/md_hilo_sequencer.md
Name: md_hilo_sequencer

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO registers for the single-cycle CPU.
- Accepts a one-cycle start from the control unit, along with the op encoding on fun_c and the rs/rt operands. It then runs a 32-step shift-add multiply or restoring divide and writes HI/LO on completion.
- It also services mthi/mtlo writes.
- Its busy output is the signal the control unit uses to gate pc_ena/start while a mult/div is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE
- fun_c  input  2  op select: 00 multu, 01 mult, 10 divu, 11 div
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- wr_hi  input  1  mthi write enable
- wr_lo  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset, including mid-operation: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Any in-flight result is discarded.
- States: IDLE, PREP, RUN, FIX.
  - IDLE & start -> PREP. On this edge, latch a, b, fun_c.
  - PREP -> RUN (counter=0).
  - RUN: counter increments each cycle. On counter==WIDTH-1 -> FIX.
  - FIX -> IDLE. On this edge, write hi and lo, and set done=1.
- busy = (state != IDLE). It is derived from the state register only, with no input-to-output combinational path.
- Timing: if start is sampled at edge E0, then busy is high for exactly WIDTH+2 cycles (34 at default). hi/lo update at edge E0+WIDTH+2. done is high for the single cycle following that edge.
- start while busy: ignored, no queuing.
- Signed ops (mult, div):
  - PREP converts both latched operands to magnitudes and records the result signs:
    - product / quotient sign = sa ^ sb
    - remainder sign = sa
  - FIX applies two's-complement negation as recorded.
  - Unsigned ops bypass sign handling.
- Multiply: the 2*WIDTH-bit product goes to {hi, lo}.
- Divide:
  - lo = quotient, hi = remainder.
  - The remainder carries the dividend's sign, and |remainder| < |divisor|.
- Divide by zero (b==0, detected in PREP):
  - Latency is unchanged.
  - Result is forced to lo = all ones and hi = latched a, for both div and divu.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap.
- mthi/mtlo:
  - wr_hi / wr_lo load wdata into hi / lo on the next edge, in any state.
  - If an operation is in flight, its FIX edge later overwrites both registers.
  - If wr_hi or wr_lo coincides with the FIX edge, the operation result wins.
  - wr_hi and wr_lo may be asserted together.
- start and wr_hi/wr_lo in the same IDLE cycle: both take effect. The operation uses the port operands, not wdata.
- hi and lo are registers. They hold their value except on reset, an mt write, or the FIX edge.

Test Plan:
- Reset mid-RUN: start mult with a=5, b=6. Assert rst at cycle 10 -> next cycle busy=0, hi=0, lo=0, done=0. No write occurs at cycle 34.
- multu vs mult: a=0xFFFFFFFF, b=0x00000002.
  - multu -> hi=0x00000001, lo=0xFFFFFFFE.
  - mult -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Both: busy high for exactly 34 cycles, then a single done pulse.
- Signed and unsigned divide:
  - div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=2 -> lo=3, hi=1.
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu a=0x1234, b=0 -> after 34 cycles lo=0xFFFFFFFF, hi=0x00001234.
- Start while busy: start divu 100/7. Pulse start with a multu at cycle 5 -> the second start is ignored. Result lo=14, hi=2, exactly one done pulse.
- mthi/mtlo collision:
  - In IDLE: wr_hi=1, wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, lo unchanged.
  - During RUN of mult 3*4: wr_lo=1 -> lo shows wdata, then is 12 after FIX.
  - wr_hi on the FIX edge -> hi=0.
